// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request, instruction buffer to decode.
// Ports: clk_in/rst_n_in, ins_mem_* request/response, branch_* redirect,
//        dec_* buffered instruction/PC handshake toward decode.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              BUF_DEPTH  = 2
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    output logic            ins_mem_valid_out,
    output logic [XLEN-1:0] ins_mem_addr_out,
    input  logic            ins_mem_ready_in,
    input  logic [XLEN-1:0] ins_mem_data_in,
    input  logic            branch_valid_in,
    input  logic [XLEN-1:0] branch_target_in,
    output logic            dec_valid_out,
    input  logic            dec_ready_in,
    output logic [XLEN-1:0] dec_ins_out,
    output logic [XLEN-1:0] dec_pc_out
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [PW:0] DEPTH = (PW + 1)'(BUF_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] buf_ins [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc  [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;

    logic full;
    logic fetch;
    logic pop;

    assign full = (count == DEPTH);

    // A redirect cancels this cycle's request so the stale PC is never fetched.
    assign ins_mem_valid_out = (state == RUN) && !full && !branch_valid_in;
    assign ins_mem_addr_out  = pc;

    assign dec_valid_out = (count != '0);
    assign dec_ins_out   = buf_ins[rd_ptr];
    assign dec_pc_out    = buf_pc[rd_ptr];

    assign fetch = ins_mem_valid_out && ins_mem_ready_in;
    // Decode may see dec_valid_out during a redirect; the pop is dropped.
    assign pop   = dec_valid_out && dec_ready_in && !branch_valid_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= BOOT;
        end else begin
            unique case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc <= RESET_ADDR;
        end else if (branch_valid_in) begin
            pc <= branch_target_in & ALIGN_MASK;
        end else if (fetch) begin
            pc <= pc + STEP;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_valid_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({fetch, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so decode outputs read zero while held.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_ins[i] <= '0;
                buf_pc[i]  <= '0;
            end
        end else if (fetch) begin
            buf_ins[wr_ptr] <= ins_mem_data_in;
            buf_pc[wr_ptr]  <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Scoreboard of expected PCs; instruction words derived from a fixed image.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_data;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_ins;
    logic [31:0] dec_pc;

    int          n_tests = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          p0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .ins_mem_valid_out (mem_valid),
        .ins_mem_addr_out  (mem_addr),
        .ins_mem_ready_in  (mem_ready),
        .ins_mem_data_in   (mem_data),
        .branch_valid_in   (br_valid),
        .branch_target_in  (br_target),
        .dec_valid_out     (dec_valid),
        .dec_ready_in      (dec_ready),
        .dec_ins_out       (dec_ins),
        .dec_pc_out        (dec_pc)
    );

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h5A5A_A5A5;
    endfunction

    assign mem_data = img(mem_addr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            sb.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic do_reset(input logic dr);
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        mem_ready = 1'b1;
        dec_ready = dr;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pop monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (rst_n && dec_valid && dec_ready && !br_valid) begin
            check("sb_has", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dec_pc", dec_pc, e);
                check("dec_ins", dec_ins, img(e));
            end
            pops++;
        end
    end

    initial begin
        #2;
        check("rst_req", 32'(mem_valid), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_dv", 32'(dec_valid), 32'd0);
        check("rst_ins", dec_ins, 32'd0);
        check("rst_pc", dec_pc, 32'd0);

        // Streaming, both sides always ready
        do_reset(1'b1);
        push_seq(32'h0, 24);
        #1;
        check("a_boot", 32'(mem_valid), 32'd0);
        step(); #1;
        check("a_req", 32'(mem_valid), 32'd1);
        check("a_addr", mem_addr, 32'h0);
        check("a_dv0", 32'(dec_valid), 32'd0);
        step(); #1;
        check("a_dv1", 32'(dec_valid), 32'd1);
        check("a_pc0", dec_pc, 32'h0);
        p0 = pops;
        repeat (8) step();
        #1;
        check("a_tput", 32'(pops - p0), 32'd8);
        check("a_addr2", mem_addr, 32'h24);

        // Decode stalled: buffer fills to two entries
        do_reset(1'b0);
        push_seq(32'h0, 8);
        repeat (6) step();
        #1;
        check("b_full_req", 32'(mem_valid), 32'd0);
        check("b_dv", 32'(dec_valid), 32'd1);
        check("b_pc", dec_pc, 32'h0);
        check("b_addr", mem_addr, 32'h8);
        step();
        dec_ready = 1'b1;
        #1;
        step(); #1;
        check("b_pc2", dec_pc, 32'h4);
        check("b_req2", 32'(mem_valid), 32'd1);
        check("b_addr2", mem_addr, 32'h8);
        repeat (4) step();

        // Memory stall at 0x10
        do_reset(1'b1);
        push_seq(32'h0, 16);
        repeat (5) step();
        mem_ready = 1'b0;
        #1;
        check("c_addr", mem_addr, 32'h10);
        check("c_req", 32'(mem_valid), 32'd1);
        step(); #1;
        check("c_hold1", mem_addr, 32'h10);
        step(); #1;
        check("c_hold2", mem_addr, 32'h10);
        check("c_drain", 32'(dec_valid), 32'd0);
        step();
        mem_ready = 1'b1;
        #1;
        check("c_hold3", mem_addr, 32'h10);
        step(); #1;
        check("c_resume", mem_addr, 32'h14);
        repeat (4) step();

        // Redirect with full buffer, misaligned target
        do_reset(1'b0);
        push_seq(32'h0, 2);
        repeat (6) step();
        #1;
        check("d_full", 32'(dec_valid), 32'd1);
        step();
        br_valid  = 1'b1;
        br_target = 32'h0000_0103;
        dec_ready = 1'b1;
        #1;
        check("d_brreq", 32'(mem_valid), 32'd0);
        check("d_brdv", 32'(dec_valid), 32'd1);
        sb.delete();
        push_seq(32'h100, 8);
        step();
        br_valid = 1'b0;
        #1;
        check("d_addr", mem_addr, 32'h100);
        check("d_flush", 32'(dec_valid), 32'd0);
        check("d_req", 32'(mem_valid), 32'd1);
        step(); #1;
        check("d_dv", 32'(dec_valid), 32'd1);
        check("d_pc", dec_pc, 32'h100);
        repeat (4) step();

        // PC wrap and back-to-back redirects
        do_reset(1'b1);
        push_seq(32'h0, 8);
        repeat (3) step();
        step();
        br_valid  = 1'b1;
        br_target = 32'hFFFF_FFFC;
        #1;
        sb.delete();
        push_seq(32'hFFFF_FFFC, 8);
        step();
        br_valid = 1'b0;
        #1;
        check("e_addr", mem_addr, 32'hFFFF_FFFC);
        step(); #1;
        check("e_wrap", mem_addr, 32'h0);
        check("e_pc", dec_pc, 32'hFFFF_FFFC);
        step(); #1;
        check("e_pc2", dec_pc, 32'h0);
        step();
        br_valid  = 1'b1;
        br_target = 32'h200;
        step();
        br_target = 32'h300;
        #1;
        sb.delete();
        push_seq(32'h300, 8);
        step();
        br_valid = 1'b0;
        #1;
        check("e_b2b", mem_addr, 32'h300);
        repeat (3) step();

        // Asynchronous reset with buffered entries
        do_reset(1'b0);
        push_seq(32'h0, 2);
        repeat (6) step();
        #1;
        check("f_full", 32'(dec_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_req", 32'(mem_valid), 32'd0);
        check("f_addr", mem_addr, 32'd0);
        check("f_dv", 32'(dec_valid), 32'd0);
        check("f_ins", dec_ins, 32'd0);
        check("f_pc", dec_pc, 32'd0);
        sb.delete();
        step();
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        push_seq(32'h0, 8);
        #1;
        check("f_boot", 32'(mem_valid), 32'd0);
        step(); #1;
        check("f_req2", 32'(mem_valid), 32'd1);
        check("f_addr2", mem_addr, 32'h0);
        check("f_dv2", 32'(dec_valid), 32'd0);
        step(); #1;
        check("f_pc2", dec_pc, 32'h0);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Holds the program counter and issues word requests to the memory over a valid/ready pair.
- Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch redirects from execute; a redirect flushes everything in flight.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- BUF_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- ins_mem_valid_out  output  1  fetch request valid.
- ins_mem_addr_out  output  XLEN  fetch byte address (current PC).
- ins_mem_ready_in  input  1  memory has data for the current request; combinational same-cycle response.
- ins_mem_data_in  input  XLEN  instruction word for ins_mem_addr_out.
- branch_valid_in  input  1  redirect request, one-cycle pulse.
- branch_target_in  input  XLEN  redirect target byte address.
- dec_valid_out  output  1  buffer head holds a valid instruction.
- dec_ready_in  input  1  decode accepts the head this cycle.
- dec_ins_out  output  XLEN  head instruction word.
- dec_pc_out  output  XLEN  PC of the head instruction.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - PC = RESET_ADDR; buffer empty (rd_ptr = wr_ptr = count = 0); FSM = BOOT.
  - All outputs 0: ins_mem_valid_out, dec_valid_out, dec_ins_out, dec_pc_out, ins_mem_addr_out.
  - Reset asserted mid-operation discards all buffered entries immediately.
- FSM:
  - BOOT: one idle cycle after reset release; no request. Next state is RUN unconditionally; a branch in BOOT still loads the PC.
  - RUN: ins_mem_valid_out = (count < BUF_DEPTH) && !branch_valid_in. ins_mem_addr_out = PC in all states.
- Fetch:
  - A fetch occurs on an edge where ins_mem_valid_out && ins_mem_ready_in.
  - On a fetch, {PC, ins_mem_data_in} is pushed at wr_ptr and PC += 4.
  - PC arithmetic is modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0000_0000.
  - When ready_in is low, the request holds, with PC unchanged, until ready_in is high.
- Decode side:
  - dec_valid_out = (count != 0).
  - dec_ins_out and dec_pc_out are driven combinationally from the entry at rd_ptr.
  - A pop occurs on an edge where dec_valid_out && dec_ready_in; rd_ptr advances.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full (count == BUF_DEPTH): no request is issued; a pop in that cycle re-enables requests the following cycle, with no same-cycle push when full.
- Empty: dec_valid_out = 0; dec_ready_in is ignored.
- Latency: an instruction fetched on edge N is visible on dec_*_out after edge N. The first instruction after reset release appears after the 2nd rising edge (BOOT + fetch).
- Throughput: 1 instruction/cycle sustained with the memory and decode both always ready.
- Redirect (branch_valid_in high) has the highest priority:
  - The fetch and pop that would occur this cycle are suppressed; the buffer is flushed (count = 0, pointers = 0).
  - PC = {branch_target_in[XLEN-1:2], 2'b00}; misaligned low bits are silently cleared.
  - dec_valid_out is still combinationally high that cycle if the buffer was non-empty. Decode must ignore it, since execute is redirecting.
  - Fetch resumes from the target on the next cycle, giving a one-cycle bubble.
  - Back-to-back redirects: the last one wins.
- Pointers wrap modulo BUF_DEPTH; count is clog2(BUF_DEPTH)+1 bits.

Test Plan:
- Reset release, memory and decode always ready, RESET_ADDR=0 -> addresses 0x0,0x4,0x8… one per cycle; first dec_valid_out after 2nd edge with dec_pc_out=0x0; dec_pc_out/dec_ins_out match the memory image in order.
- dec_ready_in held low for 5 cycles -> exactly 2 entries buffered (PC 0x0,0x4); ins_mem_valid_out low while full; raising dec_ready_in delivers 0x0,0x4,0x8 with no loss or duplication.
- ins_mem_ready_in low 3 cycles mid-stream -> ins_mem_addr_out held at same PC (e.g. 0x10); no push; resumes at 0x10 then 0x14.
- Buffer holding 2 entries, branch_valid_in pulse with target 0x0000_0103 -> buffer flushed, next request address 0x100, next dec_pc_out 0x100; no stale 0x8/0xC delivered.
- PC preloaded via branch to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- rst_n_in asserted asynchronously mid-cycle with 2 entries buffered -> outputs 0 immediately without a clock edge; after release, BOOT cycle, then fetch restarts at RESET_ADDR.
